// File: rtl/swerv_axi_arb_pkg.sv
// Shared types and constants for the AXI read-port arbiter.
// Master indices, AR request bundle and AXI response codes.
package swerv_axi_arb_pkg;

  localparam int AXI_M_IFU = 0;
  localparam int AXI_M_LSU = 1;
  localparam int AXI_M_SB  = 2;

  localparam int AXI_ID_MAX = 16;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_MAX-1:0] id;
    logic [31:0]           addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_req_t;

endpackage

// File: rtl/swerv_rr_pick.sv
// Combinational pick of one requester, starting after ptr.
// RV_AXI_RDARB_FIXED_PRIO_EN selects lowest-index-wins instead.
module swerv_rr_pick
  import swerv_axi_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [PW-1:0] gnt_idx
);

  logic hit;

`ifdef RV_AXI_RDARB_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // First requester from index 0 upward wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!hit && req[k]) begin
        hit       = 1'b1;
        gnt_oh[k] = 1'b1;
        gnt_idx   = PW'(k);
      end
    end
  end

`else

  int j;

  // Scan ptr+1, ptr+2, ... modulo N; first requester wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!hit && req[j]) begin
        hit       = 1'b1;
        gnt_oh[j] = 1'b1;
        gnt_idx   = PW'(j);
      end
    end
  end

`endif

endmodule

// File: rtl/swerv_axi_rd_arb.sv
// Shares one AXI4 read port among IFU, LSU and SB masters.
// Define RV_AXI_RDARB_FIXED_PRIO_EN for fixed priority arbitration.
module swerv_axi_rd_arb
  import swerv_axi_arb_pkg::*;
#(
  parameter  int NM      = 3,
  parameter  int IDW     = 4,
  parameter  int DW      = 64,
  parameter  int MAX_OUT = 4,
  localparam int PW      = $clog2(NM),
  localparam int MIDW    = IDW + PW,
  localparam int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [NM-1:0]     s_arvalid,
  output logic [NM-1:0]     s_arready,
  input  logic [NM*IDW-1:0] s_arid,
  input  logic [NM*32-1:0]  s_araddr,
  input  logic [NM*8-1:0]   s_arlen,
  input  logic [NM*3-1:0]   s_arsize,
  input  logic [NM*2-1:0]   s_arburst,
  output logic [NM-1:0]     s_rvalid,
  input  logic [NM-1:0]     s_rready,
  output logic [IDW-1:0]    s_rid,
  output logic [DW-1:0]     s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [MIDW-1:0]   m_arid,
  output logic [31:0]       m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [MIDW-1:0]   m_rid,
  input  logic [DW-1:0]     m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              rid_err
);

  ar_req_t       ar_q;
  ar_req_t       ar_d;
  logic          arv_q;
  logic [CW-1:0] out_cnt [NM];
  logic [NM-1:0] elig;
  logic [NM-1:0] gnt_oh;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] ptr;
  logic          slot_free;
  logic          grant;
  logic [PW-1:0] rpfx;
  logic [NM-1:0] r_hit;
  logic [NM-1:0] r_done;
  logic          r_bad;

  // A master may compete only while below its outstanding limit.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NM; i++) begin
      elig[i] = s_arvalid[i] && (out_cnt[i] < CW'(MAX_OUT));
    end
  end

  swerv_rr_pick #(
    .N  (NM),
    .PW (PW)
  ) u_pick (
    .req     (elig),
    .ptr     (ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign slot_free = !arv_q || m_arready;
  assign grant     = slot_free && (|gnt_oh);
  assign s_arready = grant ? gnt_oh : '0;

  // Mux the granted master's fields, prefixing its index onto the ID.
  always_comb begin
    ar_d = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_oh[i]) begin
        ar_d.id    = AXI_ID_MAX'({PW'(i), s_arid[i*IDW +: IDW]});
        ar_d.addr  = s_araddr[i*32 +: 32];
        ar_d.len   = s_arlen[i*8 +: 8];
        ar_d.size  = s_arsize[i*3 +: 3];
        ar_d.burst = s_arburst[i*2 +: 2];
      end
    end
  end

  // AR output register: load on grant, drop valid once accepted.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      arv_q <= 1'b0;
      ar_q  <= '0;
    end else if (grant) begin
      arv_q <= 1'b1;
      ar_q  <= ar_d;
    end else if (m_arready) begin
      arv_q <= 1'b0;
    end
  end

`ifdef RV_AXI_RDARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PW-1:0] ptr_q;

  // Last granted master; starts at NM-1 so master 0 goes first.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ptr_q <= PW'(NM - 1);
    end else if (grant) begin
      ptr_q <= gnt_idx;
    end
  end

  assign ptr = ptr_q;
`endif

  assign m_arvalid = arv_q;
  assign m_arid    = ar_q.id[MIDW-1:0];
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = ar_q.burst;

  if (MIDW < AXI_ID_MAX) begin : g_id_pad
    logic unused_id_hi;
    assign unused_id_hi = ^ar_q.id[AXI_ID_MAX-1:MIDW];
  end

  assign rpfx = m_rid[MIDW-1:IDW];

  // Steer R by ID prefix; unknown prefixes are sunk.
  always_comb begin
    r_hit    = '0;
    m_rready = 1'b1;
    for (int i = 0; i < NM; i++) begin
      if (rpfx == PW'(i)) begin
        r_hit[i] = 1'b1;
        m_rready = s_rready[i];
      end
    end
  end

  assign r_bad    = ~|r_hit;
  assign s_rvalid = m_rvalid ? r_hit : '0;
  assign r_done   = (m_rvalid && m_rready && m_rlast) ? r_hit : '0;
  assign s_rid    = m_rid[IDW-1:0];
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  // Outstanding bursts per master: +1 on grant, -1 on last beat.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NM; i++) begin
        out_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NM; i++) begin
        case ({s_arready[i], r_done[i] && (out_cnt[i] != '0)})
          2'b10:   out_cnt[i] <= out_cnt[i] + CW'(1);
          2'b01:   out_cnt[i] <= out_cnt[i] - CW'(1);
          default: out_cnt[i] <= out_cnt[i];
        endcase
      end
    end
  end

  // Sticky flag for R beats carrying an unknown master prefix.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rid_err <= 1'b0;
    end else if (m_rvalid && r_bad) begin
      rid_err <= 1'b1;
    end
  end

endmodule
